// File: rtl/letter_tracker_if.sv
// Bundle of game-side signals between the letter tracker and its environment:
// spawn handshake, key input, event pulses, counters and the renderer read port.
interface letter_tracker_if #(
  parameter int SLOTS = 8
);
  localparam int IDXW = $clog2(SLOTS);

  logic            en;
  logic            frame_tick;
  logic            spawn_valid;
  logic            spawn_ready;
  logic [7:0]      velocity;
  logic [5:0]      position;
  logic [7:0]      asciicode;
  logic            linenum;
  logic            key_valid;
  logic [7:0]      key_code;
  logic            hit;
  logic            miss;
  logic            typo;
  logic [15:0]     score;
  logic [15:0]     misses;
  logic [IDXW-1:0] rd_idx;
  logic            rd_active;
  logic [7:0]      rd_ascii;
  logic [5:0]      rd_col;
  logic [4:0]      rd_row;

  modport master (
    output en, frame_tick, spawn_valid, velocity, position, asciicode, linenum,
           key_valid, key_code, rd_idx,
    input  spawn_ready, hit, miss, typo, score, misses,
           rd_active, rd_ascii, rd_col, rd_row
  );

  modport slave (
    input  en, frame_tick, spawn_valid, velocity, position, asciicode, linenum,
           key_valid, key_code, rd_idx,
    output spawn_ready, hit, miss, typo, score, misses,
           rd_active, rd_ascii, rd_col, rd_row
  );
endinterface

// File: rtl/letter_tracker.sv
// Holds the falling letters of the typing game: spawns, moves them on frame
// ticks, matches typed keys, and keeps saturating hit and miss counters.
module letter_tracker #(
  parameter int         SLOTS  = 8,
  parameter logic [4:0] BOTTOM = 5'd29
) (
  input  logic          clk,
  input  logic          clrn,
  letter_tracker_if.slave bus
);
  localparam int IDXW = $clog2(SLOTS);

  logic        r_active [SLOTS];
  logic [7:0]  r_ascii  [SLOTS];
  logic [5:0]  r_col    [SLOTS];
  logic [4:0]  r_row    [SLOTS];
  logic [7:0]  r_step   [SLOTS];
  logic [7:0]  r_phase  [SLOTS];
  logic        r_hit;
  logic        r_miss;
  logic        r_typo;
  logic [15:0] r_score;
  logic [15:0] r_misses;

  logic            w_free_any;
  logic [IDXW-1:0] w_free_idx;
  logic            w_match_found;
  logic [IDXW-1:0] w_match_idx;
  logic [4:0]      w_best_row;
  logic            w_take;
  logic [8:0]      w_sum     [SLOTS];
  logic [4:0]      w_new_row [SLOTS];
  logic            w_kill    [SLOTS];
  logic            w_lost    [SLOTS];
  logic [4:0]      w_lost_cnt;
  logic            w_spawn;
  logic            w_key_hit;
  logic [15:0]     w_score_nxt;
  logic [16:0]     w_misses_sum;
  logic [15:0]     w_misses_nxt;

  // Lowest-index free slot, searched from the top so the lowest index wins.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = {IDXW{1'b0}};
    for (int i = SLOTS - 1; i >= 0; i--) begin
      w_free_any = w_free_any | ~r_active[i];
      w_free_idx = r_active[i] ? w_free_idx : IDXW'(i);
    end
  end

  // Key match: deepest matching letter wins, strict compare keeps the lowest index on ties.
  always_comb begin
    w_match_found = 1'b0;
    w_match_idx   = {IDXW{1'b0}};
    w_best_row    = 5'd0;
    w_take        = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      w_take        = r_active[i] && (r_ascii[i] == bus.key_code) &&
                      (!w_match_found || (r_row[i] > w_best_row));
      w_best_row    = w_take ? r_row[i] : w_best_row;
      w_match_idx   = w_take ? IDXW'(i) : w_match_idx;
      w_match_found = w_match_found | w_take;
    end
  end

  assign w_key_hit = bus.key_valid & w_match_found;

  // Per-slot movement and loss; a key removal in the same cycle pre-empts the loss.
  always_comb begin
    w_lost_cnt = 5'd0;
    for (int i = 0; i < SLOTS; i++) begin
      w_sum[i]     = {1'b0, r_phase[i]} + {1'b0, r_step[i]};
      w_new_row[i] = r_row[i] + {4'd0, w_sum[i][8]};
      w_kill[i]    = w_key_hit && (w_match_idx == IDXW'(i));
      w_lost[i]    = bus.frame_tick && r_active[i] && !w_kill[i] &&
                     (w_new_row[i] >= BOTTOM);
      w_lost_cnt   = w_lost_cnt + {4'd0, w_lost[i]};
    end
  end

  assign w_spawn      = bus.spawn_valid & w_free_any;
  assign w_score_nxt  = (r_score == 16'hFFFF) ? r_score : (r_score + 16'd1);
  assign w_misses_sum = {1'b0, r_misses} + {12'd0, w_lost_cnt};
  assign w_misses_nxt = w_misses_sum[16] ? 16'hFFFF : w_misses_sum[15:0];

  // Slot array, event pulses and counters.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_active[i] <= 1'b0;
        r_ascii[i]  <= 8'd0;
        r_col[i]    <= 6'd0;
        r_row[i]    <= 5'd0;
        r_step[i]   <= 8'd0;
        r_phase[i]  <= 8'd0;
      end
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_typo   <= 1'b0;
      r_score  <= 16'd0;
      r_misses <= 16'd0;
    end else if (!bus.en) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_active[i] <= 1'b0;
        r_ascii[i]  <= 8'd0;
        r_col[i]    <= 6'd0;
        r_row[i]    <= 5'd0;
        r_step[i]   <= 8'd0;
        r_phase[i]  <= 8'd0;
      end
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      r_typo <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_kill[i] || w_lost[i]) begin
          r_active[i] <= 1'b0;
          r_ascii[i]  <= 8'd0;
          r_col[i]    <= 6'd0;
          r_row[i]    <= 5'd0;
          r_step[i]   <= 8'd0;
          r_phase[i]  <= 8'd0;
        end else if (w_spawn && (w_free_idx == IDXW'(i))) begin
          r_active[i] <= 1'b1;
          r_ascii[i]  <= bus.asciicode;
          r_col[i]    <= bus.position;
          r_row[i]    <= {4'd0, bus.linenum};
          r_step[i]   <= {1'b1, bus.velocity[7:1]};
          r_phase[i]  <= 8'd0;
        end else if (bus.frame_tick && r_active[i]) begin
          r_row[i]    <= w_new_row[i];
          r_phase[i]  <= w_sum[i][7:0];
        end else begin
          r_active[i] <= r_active[i];
        end
      end
      r_hit    <= w_key_hit;
      r_typo   <= bus.key_valid & ~w_match_found;
      r_miss   <= (w_lost_cnt != 5'd0);
      r_misses <= w_misses_nxt;
      if (w_key_hit) begin
        r_score <= w_score_nxt;
      end else begin
        r_score <= r_score;
      end
    end
  end

  assign bus.spawn_ready = bus.en & w_free_any;
  assign bus.hit         = r_hit;
  assign bus.miss        = r_miss;
  assign bus.typo        = r_typo;
  assign bus.score       = r_score;
  assign bus.misses      = r_misses;
  assign bus.rd_active   = r_active[bus.rd_idx];
  assign bus.rd_ascii    = r_ascii[bus.rd_idx];
  assign bus.rd_col      = r_col[bus.rd_idx];
  assign bus.rd_row      = r_row[bus.rd_idx];
endmodule

// File: doc/letter_tracker.md
# letter_tracker

Consumer of the falling-letter generator in the typing game. It accepts spawn records carrying velocity, column, ASCII code and start line, and holds up to SLOTS active letters. It advances each letter downward on every frame tick and matches typed key codes against the active letters. It reports hits, misses and typos, keeps score and miss counters, and exposes a random-access read port for the VGA renderer.

## Interface
- SLOTS, 8, number of letter slots (power of two, 2..16)
- BOTTOM, 29, row at which a letter is lost (5-bit, >= 2)
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- en  in  1  game running; low synchronously clears all slots
- frame_tick  in  1  one-cycle pulse, one movement step
- spawn_valid  in  1  spawn record present
- spawn_ready  out  1  en & (any slot free), combinational from registered state
- velocity  in  8  speed code of the spawn record
- position  in  6  column 1..52
- asciicode  in  8  letter code
- linenum  in  1  start row (0 or 1)
- key_valid  in  1  one-cycle pulse, key pressed
- key_code  in  8  ASCII of the pressed key
- hit  out  1  pulse: key removed a letter
- miss  out  1  pulse: at least one letter reached BOTTOM
- typo  out  1  pulse: key matched nothing
- score  out  16  hit count, saturating
- misses  out  16  lost-letter count, saturating
- rd_idx  in  log2(SLOTS)  slot select for the renderer
- rd_active, rd_ascii[7:0], rd_col[5:0], rd_row[4:0]  out  combinational view of slot rd_idx

## Operation
- Per-slot state: active, ascii[7:0], col[5:0], row[4:0], step[7:0], phase[7:0].
- Spawn: on spawn_valid & spawn_ready, the lowest-index free slot loads active=1, ascii, col=position, row=linenum, phase=0, step={1'b1, velocity[7:1]} (128..255). A letter therefore moves 0.5..~1 rows per tick.
- Movement: on frame_tick, each active slot computes the 9-bit sum phase+step. phase takes the low 8 bits and the carry increments row.
- Loss: if a slot's new row >= BOTTOM, the slot clears in that same update. misses increases by the number of slots lost and miss pulses once.
- Match: on key_valid, the candidates are the active slots with ascii == key_code. The winner is the candidate with the largest row, with ties going to the lowest index. The winner is cleared, score increments by 1 and hit pulses. With no candidate, typo pulses and no state changes.
- Simultaneous events in one cycle are all evaluated on the pre-update state:
  - Key removal wins over movement and loss for the same slot; the letter counts as a hit, not a miss.
  - A spawn uses the lowest slot that is free in the pre-update state. A slot freed this cycle is not reusable until the next cycle.
  - A spawned slot does not move on the cycle it is written.
- Counters saturate at 16'hFFFF without wrapping. They are cleared only by clrn.
- en=0 has the following effect:
  - All slots clear next edge.
  - key_valid, frame_tick and spawn_valid are ignored.
  - hit, miss and typo stay low.
  - score and misses hold.
  - spawn_ready=0.

## Timing
- Reset (clrn low, asynchronous) sets:
  - all slots inactive and all slot fields to 0;
  - score=0, misses=0;
  - hit=miss=typo=0.
- spawn_ready and rd_* are combinational. All other outputs are registered.
- Spawn latency: the record is visible on the read port the cycle after the handshake edge.
- Key latency: hit/typo assert exactly one cycle after key_valid, for one cycle. score updates on the same edge.
- Miss latency: miss asserts one cycle after the frame_tick that causes the loss. misses updates on the same edge.
- Back-to-back key_valid on consecutive cycles must each be processed; the second key sees the first key's removal.
- Full condition: with SLOTS active, spawn_ready=0 and spawn_valid is held off with no loss of the record.
- Mid-operation clrn assertion clears everything immediately. On release, the first active edge behaves as from idle.

## Test plan
- Reset/idle: clrn low then high, en=1 -> spawn_ready=1, score=0, misses=0, all rd_active=0.
- Spawn and move: spawn velocity=8'hFE, position=10, ascii 8'h61, linenum=1, then 4 frame_ticks -> slot 0 row=1 before the ticks, step=255, row=4 after 4 ticks with phase=8'hFC. Velocity 8'h00 (step=128) -> row +1 every 2 ticks.
- Match priority: slot0 'a' at row 3, slot1 'a' at row 7, slot2 'b' at row 7, then key 8'h61 -> slot1 cleared, hit=1 one cycle later, score=1. Key 8'h7A -> typo=1, no change.
- Loss and simultaneity:
  - One letter at row BOTTOM-1 with phase near overflow; frame_tick -> slot cleared, miss=1, misses=1.
  - Repeat with key_valid for that letter in the same cycle -> hit=1, miss=0, score+1.
- Full/back-pressure: fill 8 slots -> spawn_ready=0. Key hits slot 3 in the same cycle as a pending spawn -> spawn accepted next cycle into slot 3.
- en drop and saturation: deassert en with letters active -> all slots clear next edge and counters hold. Force score to 16'hFFFF, hit again -> score stays 16'hFFFF.
